// File: rtl/ahb_lite_ram_subordinate_pkg.sv
// Shared encodings and helpers for the AHB-Lite RAM subordinate.
// Contents: HTRANS/HSIZE encodings, FSM state enum, byte-enable decode function.
package ahb_lite_ram_subordinate_pkg;

  typedef enum logic [1:0] {
    HTransIdle   = 2'd0,
    HTransBusy   = 2'd1,
    HTransNonseq = 2'd2,
    HTransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSizeByte = 3'd0,
    HSizeHalf = 3'd1,
    HSizeWord = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  // Byte lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] fu_byte_enable(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSizeByte: be = 4'b0001 << addr;
      HSizeHalf: be = addr[1] ? 4'b1100 : 4'b0011;
      HSizeWord: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_lite_ram_subordinate_if.sv
// AHB-Lite bus bundle between a master and the RAM subordinate.
// master drives address/control/write data and hReady; slave returns hReadyOut, hResp, hRData.
interface ahb_lite_ram_subordinate_if;
  logic        hSel;
  logic [31:0] hAddr;
  logic [1:0]  hTrans;
  logic        hWrite;
  logic [2:0]  hSize;
  logic [31:0] hWData;
  logic        hReady;
  logic        hReadyOut;
  logic        hResp;
  logic [31:0] hRData;

  modport master (
    output hSel, hAddr, hTrans, hWrite, hSize, hWData, hReady,
    input  hReadyOut, hResp, hRData
  );

  modport slave (
    input  hSel, hAddr, hTrans, hWrite, hSize, hWData, hReady,
    output hReadyOut, hResp, hRData
  );
endinterface

// File: rtl/ahb_lite_ram_subordinate_array.sv
// Depth x 32-bit word array with per-byte write enables.
// Ports: clk_i clock; we_i byte-lane write enables; addr_i word index (shared by read and write);
// wdata_i write data; rdata_o asynchronous read data. Contents are not reset.
module ahb_lite_ram_subordinate_array #(
  parameter int unsigned Depth = 256
) (
  input  logic                     clk_i,
  input  logic [3:0]               we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_ram_subordinate.sv
// AHB-Lite subordinate fronting a word-organised RAM with programmable wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
// Ports: ckPeri clock; rstN synchronous active-low reset; bus AHB-Lite slave modport.
module ahb_lite_ram_subordinate
  import ahb_lite_ram_subordinate_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                         ckPeri,
  input logic                         rstN,
  ahb_lite_ram_subordinate_if.slave   bus
);

  localparam int unsigned AddrW     = $clog2(DEPTH);
  localparam int unsigned ByteAddrW = AddrW + 2;
  localparam logic [1:0]  WaitLoad  = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ByteAddrW-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [2:0]           size_q, size_d;
  logic                 ready_q, ready_d;
  logic                 resp_q, resp_d;

  logic                 accept;
  logic                 illegal;
  logic [3:0]           we;
  logic [31:0]          rdata;

  assign accept = bus.hSel && bus.hReady &&
                  (bus.hTrans == HTransNonseq || bus.hTrans == HTransSeq);

  always_comb begin
    illegal = 1'b0;
    if (bus.hAddr[31:ByteAddrW] != '0) illegal = 1'b1;
    case (bus.hSize)
      HSizeByte: ;
      HSizeHalf: if (bus.hAddr[0]) illegal = 1'b1;
      HSizeWord: if (bus.hAddr[1:0] != 2'b00) illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      StWait: begin
        if (cnt_q == 2'd0) state_d = StData;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StErr1: state_d = StErr2;
      // IDLE, DATA and ERR2 all close with hReadyOut high, so each can take a new address phase.
      default: begin
        if (accept) begin
          addr_d  = bus.hAddr[ByteAddrW-1:0];
          write_d = bus.hWrite;
          size_d  = bus.hSize;
          if (illegal) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StData;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
    ready_d = !(state_d inside {StWait, StErr1});
    resp_d  = state_d inside {StErr1, StErr2};
  end

  always_ff @(posedge ckPeri) begin
    if (!rstN) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
    end
  end

  // Gating with rstN drops a write whose data phase coincides with reset.
  assign we = (state_q == StData && write_q && rstN) ? fu_byte_enable(addr_q[1:0], size_q)
                                                     : 4'b0000;

  ahb_lite_ram_subordinate_array #(
    .Depth (DEPTH)
  ) u_array (
    .clk_i   (ckPeri),
    .we_i    (we),
    .addr_i  (addr_q[ByteAddrW-1:2]),
    .wdata_i (bus.hWData),
    .rdata_o (rdata)
  );

  assign bus.hReadyOut = ready_q;
  assign bus.hResp     = resp_q;
  assign bus.hRData    = (state_q == StData && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_ram_subordinate.sv
// Directed bench for ahb_lite_ram_subordinate: one zero-wait and one two-wait instance, a
// transfer-level reference model checked every cycle, and literal expectations per scenario.
module tb_ahb_lite_ram_subordinate;

  localparam int Depth = 256;
  localparam int NBytes = Depth * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst2_n;
  logic tgt;  // 0 selects the zero-wait instance, 1 the two-wait instance
  logic sel, wr;
  logic [1:0] trans;
  logic [2:0] size;
  logic [31:0] addr, wdata;

  ahb_lite_ram_subordinate_if bus0 ();
  ahb_lite_ram_subordinate_if bus2 ();

  assign bus0.hSel   = sel & ~tgt;
  assign bus0.hAddr  = addr;
  assign bus0.hTrans = trans;
  assign bus0.hWrite = wr;
  assign bus0.hSize  = size;
  assign bus0.hWData = wdata;
  assign bus0.hReady = bus0.hReadyOut;

  assign bus2.hSel   = sel & tgt;
  assign bus2.hAddr  = addr;
  assign bus2.hTrans = trans;
  assign bus2.hWrite = wr;
  assign bus2.hSize  = size;
  assign bus2.hWData = wdata;
  assign bus2.hReady = bus2.hReadyOut;

  ahb_lite_ram_subordinate #(.DEPTH(Depth), .WAIT_STATES(0)) dut0 (
    .ckPeri (clk), .rstN (rst0_n), .bus (bus0)
  );
  ahb_lite_ram_subordinate #(.DEPTH(Depth), .WAIT_STATES(2)) dut2 (
    .ckPeri (clk), .rstN (rst2_n), .bus (bus2)
  );

  logic cur_ready;
  assign cur_ready = tgt ? bus2.hReadyOut : bus0.hReadyOut;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one outstanding transfer per instance ----------------
  logic [7:0]  mem_m [2][NBytes];
  bit          act_m [2] = '{0, 0};
  bit          ill_m [2];
  bit          wr_m [2];
  int          left_m [2];
  int unsigned addr_m [2];
  int unsigned size_m [2];
  logic [31:0] last_rdata [2];
  int          low_cnt [2] = '{0, 0};
  int          resp_cnt [2] = '{0, 0};

  task automatic model_step(input int d, input int ws, input logic sel_d, input logic rstn_d,
                            input logic dut_ready, input logic dut_resp,
                            input logic [31:0] dut_rdata);
    logic e_ready, e_resp;
    logic [31:0] e_rdata;
    int unsigned a, nb;
    bit legal;
    e_ready = 1'b1;
    e_resp  = 1'b0;
    e_rdata = 32'h0;
    if (act_m[d]) begin
      e_ready = (left_m[d] == 0);
      e_resp  = ill_m[d];
      if (e_ready && !ill_m[d] && !wr_m[d]) begin
        a = addr_m[d] & ~32'd3;
        e_rdata = {mem_m[d][a+3], mem_m[d][a+2], mem_m[d][a+1], mem_m[d][a]};
      end
    end
    chk($sformatf("dut%0d hReadyOut", d), {31'b0, dut_ready}, {31'b0, e_ready});
    chk($sformatf("dut%0d hResp", d), {31'b0, dut_resp}, {31'b0, e_resp});
    chk($sformatf("dut%0d hRData", d), dut_rdata, e_rdata);
    if (!dut_ready) low_cnt[d]++;
    if (dut_resp) resp_cnt[d]++;

    if (act_m[d]) begin
      if (left_m[d] == 0) begin
        act_m[d] = 1'b0;
        if (!ill_m[d] && !wr_m[d]) last_rdata[d] = dut_rdata;
        if (!ill_m[d] && wr_m[d] && rstn_d) begin
          nb = 1 << size_m[d];
          for (int i = 0; i < int'(nb); i++) begin
            a = addr_m[d] + i;
            mem_m[d][a] = wdata[8*(a%4) +: 8];
          end
        end
      end else begin
        left_m[d]--;
      end
    end

    if (!rstn_d) begin
      act_m[d] = 1'b0;
    end else if (e_ready && sel_d && trans[1]) begin
      legal = (addr < NBytes) && (size <= 3'd2);
      if (legal) legal = (addr % (1 << size)) == 0;
      act_m[d]  = 1'b1;
      ill_m[d]  = !legal;
      wr_m[d]   = wr;
      addr_m[d] = addr;
      size_m[d] = size;
      left_m[d] = legal ? ws : 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      model_step(0, 0, sel & ~tgt, rst0_n, bus0.hReadyOut, bus0.hResp, bus0.hRData);
      model_step(1, 2, sel & tgt, rst2_n, bus2.hReadyOut, bus2.hResp, bus2.hRData);
    end
  end

  // ---------------- pipelined master driver ----------------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  s;
    logic [31:0] wd;
  } xfer_t;
  xfer_t xq[$];

  task automatic add(input logic w, input logic [31:0] a, input logic [2:0] s,
                     input logic [31:0] wd);
    xfer_t x;
    x.w = w; x.a = a; x.s = s; x.wd = wd;
    xq.push_back(x);
  endtask

  // Called and returns at posedge+1; drains xq and waits for the final data phase.
  task automatic run_xfers();
    xfer_t x;
    int guard = 0;
    logic r;
    logic [31:0] next_wd = wdata;
    while (xq.size() > 0 && guard < 200) begin
      x = xq[0];
      sel = 1'b1; trans = 2'd2; addr = x.a; wr = x.w; size = x.s;
      @(negedge clk);
      if (cur_ready) begin
        void'(xq.pop_front());
        next_wd = x.wd;
      end
      @(posedge clk); #1;
      wdata = next_wd;
      guard++;
    end
    sel = 1'b0; trans = 2'd0;
    do begin
      @(negedge clk);
      r = cur_ready;
      @(posedge clk); #1;
      guard++;
    end while (!r && guard < 200);
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL run_xfers timeout got %0d cycles want <200", guard);
      xq.delete();
    end
  endtask

  int c0, l0, r0;

  initial begin
    sel = 0; trans = 0; addr = 0; wr = 0; size = 0; wdata = 0; tgt = 0;
    rst0_n = 0; rst2_n = 0;
    repeat (3) @(posedge clk);
    #1 rst0_n = 1; rst2_n = 1; chk_en = 1;

    // Reset state, literal.
    @(negedge clk);
    chk("reset ready0", {31'b0, bus0.hReadyOut}, 32'd1);
    chk("reset resp0", {31'b0, bus0.hResp}, 32'd0);
    chk("reset rdata0", bus0.hRData, 32'h0);
    chk("reset ready2", {31'b0, bus2.hReadyOut}, 32'd1);
    @(posedge clk); #1;

    // Zero-wait word write/read.
    l0 = low_cnt[0];
    add(1, 32'h10, 3'd2, 32'hDEADBEEF);
    add(0, 32'h10, 3'd2, 32'h0);
    run_xfers();
    chk("ws0 rd 0x10", last_rdata[0], 32'hDEADBEEF);
    chk("ws0 no wait", low_cnt[0] - l0, 32'd0);

    // Byte and halfword lanes on top of a known word.
    add(1, 32'h20, 3'd2, 32'h55667788);
    add(1, 32'h21, 3'd0, 32'h00001100);
    add(1, 32'h22, 3'd1, 32'hAABB0000);
    add(0, 32'h20, 3'd2, 32'h0);
    run_xfers();
    chk("ws0 lanes 0x20", last_rdata[0], 32'hAABB1188);

    // Write immediately followed by read of the same word.
    add(1, 32'h0, 3'd2, 32'h12345678);
    add(0, 32'h0, 3'd2, 32'h0);
    run_xfers();
    chk("ws0 wr->rd 0x0", last_rdata[0], 32'h12345678);

    // Illegal: misaligned word write.
    l0 = low_cnt[0]; r0 = resp_cnt[0];
    add(1, 32'h12, 3'd2, 32'hFFFFFFFF);
    run_xfers();
    chk("err misalign resp cycles", resp_cnt[0] - r0, 32'd2);
    chk("err misalign low cycles", low_cnt[0] - l0, 32'd1);
    add(0, 32'h10, 3'd2, 32'h0);
    run_xfers();
    chk("err misalign mem", last_rdata[0], 32'hDEADBEEF);

    // Illegal: out of range (would alias word 0).
    r0 = resp_cnt[0];
    add(1, NBytes, 3'd2, 32'h0);
    run_xfers();
    chk("err range resp cycles", resp_cnt[0] - r0, 32'd2);
    add(0, 32'h0, 3'd2, 32'h0);
    run_xfers();
    chk("err range mem", last_rdata[0], 32'h12345678);

    // Illegal: hSize=3.
    r0 = resp_cnt[0];
    add(1, 32'h20, 3'd3, 32'h0);
    run_xfers();
    chk("err size resp cycles", resp_cnt[0] - r0, 32'd2);
    add(0, 32'h20, 3'd2, 32'h0);
    run_xfers();
    chk("err size mem", last_rdata[0], 32'hAABB1188);

    // Two wait states: back-to-back reads.
    tgt = 1;
    add(1, 32'h100, 3'd2, 32'hA0A0A0A1);
    add(1, 32'h104, 3'd2, 32'hB0B0B0B2);
    add(1, 32'h108, 3'd2, 32'hC0C0C0C3);
    run_xfers();
    c0 = cyc; l0 = low_cnt[1];
    add(0, 32'h100, 3'd2, 32'h0);
    add(0, 32'h104, 3'd2, 32'h0);
    add(0, 32'h108, 3'd2, 32'h0);
    run_xfers();
    chk("ws2 low cycles", low_cnt[1] - l0, 32'd6);
    chk("ws2 total cycles", cyc - c0, 32'd10);
    chk("ws2 last rdata", last_rdata[1], 32'hC0C0C0C3);

    // ERROR latency independent of wait states.
    l0 = low_cnt[1]; r0 = resp_cnt[1];
    add(0, 32'h104, 3'd3, 32'h0);
    run_xfers();
    chk("ws2 err low cycles", low_cnt[1] - l0, 32'd1);
    chk("ws2 err resp cycles", resp_cnt[1] - r0, 32'd2);

    // Reset during the wait of a write drops it.
    sel = 1; trans = 2'd2; addr = 32'h100; wr = 1; size = 3'd2;
    @(posedge clk); #1;
    sel = 0; trans = 2'd0; wdata = 32'h0BADBAD0;
    rst2_n = 0;
    @(posedge clk); #1;
    rst2_n = 1;
    @(negedge clk);
    chk("mid reset ready", {31'b0, bus2.hReadyOut}, 32'd1);
    chk("mid reset resp", {31'b0, bus2.hResp}, 32'd0);
    @(posedge clk); #1;
    add(0, 32'h100, 3'd2, 32'h0);
    run_xfers();
    chk("mid reset mem", last_rdata[1], 32'hA0A0A0A1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_ram_subordinate.md
# ahb_lite_ram_subordinate

AHB-Lite subordinate (responder) fronting a word-organised RAM, the responder end of the peripheral subsystem RAM bus driven by the AHB-Lite master. It decodes address/data-phase pipelined transfers, supports byte/halfword/word accesses with byte-lane writes, and inserts programmable wait states. It returns a two-cycle ERROR response on illegal transfers. It serves as both the RAM model for subsystem benches and a synthesizable scratch RAM.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, 16..4096.
- WAIT_STATES, 0: wait cycles inserted per OKAY data phase, 0..3.
- ckPeri  in  1  peripheral clock; all logic on its rising edge.
- rstN  in  1  reset; synchronous, active-low.
- hSel  in  1  subordinate select.
- hAddr  in  32  byte address; only bits [log2(DEPTH)+1:0] decoded, the upper bits are range-checked.
- hTrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hWrite  in  1  1=write.
- hSize  in  3  0=byte, 1=halfword, 2=word; >2 is illegal.
- hWData  in  32  write data, valid in the data phase.
- hReady  in  1  bus-level ready; address phase is accepted only when high.
- hReadyOut  out  1  subordinate ready.
- hResp  out  1  0=OKAY, 1=ERROR.
- hRData  out  32  read data, valid when hReadyOut=1 in an OKAY read data phase, else 0.

## Operation
- Transfer accepted when hSel & hReady & hTrans[1]. IDLE/BUSY or unselected: no action, zero-wait OKAY.
- On acceptance, register addr, write, size; classify the transfer.
  - Illegal if addr >= DEPTH*4, hSize>2, halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states:
  - IDLE: a legal transfer goes to WAIT if WAIT_STATES>0, else to DATA. An illegal transfer goes to ERR1.
  - WAIT: counter loads WAIT_STATES-1 and decrements; hReadyOut=0. At 0, goes to DATA.
  - DATA: hReadyOut=1, hResp=0. A write commits byte lanes of hWData to the array at the closing edge. A read drives the lane-aligned full word; all 32 bits come from the array word.
    - Closing edge with a new accepted transfer: goes to WAIT, DATA or ERR1 accordingly. No new transfer: goes to IDLE.
  - ERR1: hReadyOut=0, hResp=1; goes to ERR2.
  - ERR2: hReadyOut=1, hResp=1; the array is not modified. Closing edge accepts a new transfer exactly as DATA does.
- Byte enables:
  - byte: lane addr[1:0].
  - halfword: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
- Array contents are not reset. The reset value is X in simulation.
- A BUSY or IDLE during a wait/error data phase is ignored; only hReady-qualified phases are sampled.

## Timing
- Reset (rstN=0 at a rising edge): state=IDLE, counter=0, registered phase=none, hReadyOut=1, hResp=0, hRData=0. Applies mid-transfer; a pending write is dropped.
- OKAY latency: the data phase completes in 1+WAIT_STATES cycles after the address phase.
- ERROR latency: 2 cycles, always, independent of WAIT_STATES.
- Back-to-back address phases are pipelined under the current data phase; zero-wait throughput is 1 transfer/cycle.
- Write then read of the same word in consecutive transfers: the read returns the new data. The write commits at the edge that opens the read data phase, so no forwarding is needed.
- hRData is combinational from the array and the registered address during a read DATA state.

## Structure
- Package pa_AhbRamSub holds:
  - HTRANS and HSIZE encodings.
  - State enum {IDLE, WAIT, DATA, ERR1, ERR2}.
  - Function fu_ByteEnable(addr[1:0], size) returning the 4-bit byte enable.
- Sub-module ahb_ram_array: DEPTH x 32 array with a 4-bit byte-write enable, synchronous write, and asynchronous read. The top level holds the FSM, counter, and decode.

## Test plan
- Reset with WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10. hRData=0xDEADBEEF, hResp=0, no hReadyOut low cycles.
- Byte/halfword writes to 0x20: byte 0x11 @0x21, halfword 0xAABB @0x22. Word read @0x20 returns 0xAABB11xx, with lane 0 unchanged.
- WAIT_STATES=2 with back-to-back NONSEQ reads: hReadyOut low exactly 2 cycles per transfer, and 3 cycles per transfer total.
- Illegal transfers, each gives ERR1 then ERR2 (2-cycle ERROR) and leaves memory unchanged:
  - word write @0x12;
  - write @DEPTH*4;
  - hSize=3.
- Write 0x12345678 @0x0 immediately followed by a read @0x0. The read returns 0x12345678.
- Assert rstN=0 during WAIT of a write. Next cycle: hReadyOut=1, hResp=0, and the target word is unchanged.
